// File: rtl/scarv_cop_dispatch.sv
// Crypto-coprocessor issue controller: accept, decode check, issue to one FU, respond; best case 3 cycles accept-to-response.
// Backpressure: one instruction in flight, ack only in IDLE, response held until cpu_rsp_ready. Option SCARV_COP_DISPATCH_PERF_EN adds counters.
module scarv_cop_dispatch #(
  parameter logic [6:0]  FEATURE_MASK = 7'h7F,
  parameter int unsigned MAX_CYCLES   = 64
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cpu_insn_req,
  output logic        cpu_insn_ack,
  input  logic [31:0] cpu_insn_enc,
  output logic        cpu_rsp_valid,
  input  logic        cpu_rsp_ready,
  output logic [1:0]  cpu_rsp_status,
  output logic [31:0] dec_encoded,
  input  logic        id_exception,
  input  logic [2:0]  id_class,
  output logic [6:0]  fu_ivalid,
  input  logic [6:0]  fu_idone,
`ifdef SCARV_COP_DISPATCH_PERF_EN
  output logic [31:0] perf_retired,
  output logic [15:0] perf_faults,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [1:0]  ST_OK       = 2'd0;
  localparam logic [1:0]  ST_ILLEGAL  = 2'd1;
  localparam logic [1:0]  ST_DISABLED = 2'd2;
  localparam logic [1:0]  ST_TIMEOUT  = 2'd3;
  localparam logic [15:0] WD_LIMIT    = 16'(MAX_CYCLES - 1);

  state_t      state_q;
  logic [31:0] enc_q;
  logic [2:0]  cls_q;
  logic [15:0] wd_q;
  logic        rsp_vld_q;
  logic [1:0]  status_q;

  logic [7:0]  mask_ext;
  logic [6:0]  cls_onehot;
  logic        done_hit;

  // Class 7 indexes the zero pad, so it can never look enabled.
  assign mask_ext   = {1'b0, FEATURE_MASK};
  assign cls_onehot = 7'b000_0001 << cls_q;
  assign done_hit   = |(fu_idone & cls_onehot);

  assign cpu_insn_ack   = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign fu_ivalid      = (state_q == S_EXEC) ? cls_onehot : 7'd0;
  assign cpu_rsp_valid  = rsp_vld_q;
  assign cpu_rsp_status = status_q;
  assign dec_encoded    = enc_q;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q   <= S_IDLE;
      enc_q     <= 32'd0;
      cls_q     <= 3'd0;
      wd_q      <= 16'd0;
      rsp_vld_q <= 1'b0;
      status_q  <= ST_OK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_insn_req) begin
            enc_q   <= cpu_insn_enc;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (id_exception || (id_class == 3'd7)) begin
            status_q  <= ST_ILLEGAL;
            rsp_vld_q <= 1'b1;
            state_q   <= S_RESP;
          end else if (!mask_ext[id_class]) begin
            status_q  <= ST_DISABLED;
            rsp_vld_q <= 1'b1;
            state_q   <= S_RESP;
          end else begin
            cls_q   <= id_class;
            wd_q    <= 16'd0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (done_hit) begin
            status_q  <= ST_OK;
            rsp_vld_q <= 1'b1;
            state_q   <= S_RESP;
          end else if (wd_q == WD_LIMIT) begin
            status_q  <= ST_TIMEOUT;
            rsp_vld_q <= 1'b1;
            state_q   <= S_RESP;
          end else begin
            wd_q <= wd_q + 16'd1;
          end
        end
        S_RESP: begin
          if (cpu_rsp_ready) begin
            rsp_vld_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SCARV_COP_DISPATCH_PERF_EN
  logic [31:0] retired_q;
  logic [15:0] faults_q;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      retired_q <= 32'd0;
      faults_q  <= 16'd0;
    end else if (rsp_vld_q && cpu_rsp_ready) begin
      if (status_q == ST_OK) retired_q <= retired_q + 32'd1;
      else                   faults_q  <= faults_q + 16'd1;
    end
  end

  assign perf_retired = retired_q;
  assign perf_faults  = faults_q;
`endif

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// Directed bench for scarv_cop_dispatch with FEATURE_MASK=7'h7B, MAX_CYCLES=4.
// The decoder is modelled as class=enc[2:0], exception=enc[31].
module tb_scarv_cop_dispatch;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        cpu_insn_req = 1'b0;
  logic        cpu_insn_ack;
  logic [31:0] cpu_insn_enc = 32'd0;
  logic        cpu_rsp_valid;
  logic        cpu_rsp_ready = 1'b1;
  logic [1:0]  cpu_rsp_status;
  logic [31:0] dec_encoded;
  logic        id_exception;
  logic [2:0]  id_class;
  logic [6:0]  fu_ivalid;
  logic [6:0]  fu_idone = 7'd0;
  logic        busy;
`ifdef SCARV_COP_DISPATCH_PERF_EN
  logic [31:0] perf_retired;
  logic [15:0] perf_faults;
`endif

  int checks = 0;
  int failures = 0;

  assign id_class     = dec_encoded[2:0];
  assign id_exception = dec_encoded[31];

  scarv_cop_dispatch #(.FEATURE_MASK(7'h7B), .MAX_CYCLES(4)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack), .cpu_insn_enc(cpu_insn_enc),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready), .cpu_rsp_status(cpu_rsp_status),
    .dec_encoded(dec_encoded), .id_exception(id_exception), .id_class(id_class),
    .fu_ivalid(fu_ivalid), .fu_idone(fu_idone),
`ifdef SCARV_COP_DISPATCH_PERF_EN
    .perf_retired(perf_retired), .perf_faults(perf_faults),
`endif
    .busy(busy)
  );

  initial forever #5 g_clk = ~g_clk;

  task automatic nclk();
    @(negedge g_clk);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the DECODE cycle.
  task automatic send(input logic [31:0] enc);
    cpu_insn_enc = enc;
    cpu_insn_req = 1'b1;
    nclk();
    cpu_insn_req = 1'b0;
    cpu_insn_enc = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset();
    nclk();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cpu_insn_ack !== 1'b1) begin failures++; $display("FAIL reset_ack got=%b exp=1", cpu_insn_ack); end
    checks++; if (cpu_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", cpu_rsp_valid); end
    checks++; if (cpu_rsp_status !== 2'd0) begin failures++; $display("FAIL reset_status got=%0d exp=0", cpu_rsp_status); end
    checks++; if (fu_ivalid !== 7'd0) begin failures++; $display("FAIL reset_fu_ivalid got=%b exp=0", fu_ivalid); end
    checks++; if (dec_encoded !== 32'd0) begin failures++; $display("FAIL reset_dec_encoded got=%h exp=0", dec_encoded); end
`ifdef SCARV_COP_DISPATCH_PERF_EN
    checks++; if (perf_retired !== 32'd0 || perf_faults !== 16'd0) begin failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_retired, perf_faults); end
`endif
  endtask

  task automatic test_legal();
    checks++; if (cpu_insn_ack !== 1'b1) begin failures++; $display("FAIL legal_ack got=%b exp=1", cpu_insn_ack); end
    send(32'h0ABC_DEF3);
    checks++; if (dec_encoded !== 32'h0ABC_DEF3) begin failures++; $display("FAIL legal_dec_encoded got=%h exp=0abcdef3", dec_encoded); end
    checks++; if (fu_ivalid !== 7'd0 || busy !== 1'b1 || cpu_insn_ack !== 1'b0) begin failures++; $display("FAIL legal_decode_cycle got=ivalid %b busy %b ack %b exp=0000000 1 0", fu_ivalid, busy, cpu_insn_ack); end
    nclk();
    checks++; if (fu_ivalid !== 7'b0001000) begin failures++; $display("FAIL legal_fu_ivalid got=%b exp=0001000", fu_ivalid); end
    checks++; if (cpu_rsp_valid !== 1'b0) begin failures++; $display("FAIL legal_early_rsp got=%b exp=0", cpu_rsp_valid); end
    fu_idone = 7'b0001000;
    nclk();
    fu_idone = 7'd0;
    checks++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_status !== 2'd0) begin failures++; $display("FAIL legal_rsp got=valid %b status %0d exp=1 0", cpu_rsp_valid, cpu_rsp_status); end
    checks++; if (fu_ivalid !== 7'd0) begin failures++; $display("FAIL legal_ivalid_drop got=%b exp=0", fu_ivalid); end
    nclk();
    checks++; if (busy !== 1'b0 || cpu_rsp_valid !== 1'b0) begin failures++; $display("FAIL legal_idle got=busy %b valid %b exp=0 0", busy, cpu_rsp_valid); end
    checks++; if (dec_encoded !== 32'h0ABC_DEF3) begin failures++; $display("FAIL legal_dec_hold got=%h exp=0abcdef3", dec_encoded); end
  endtask

  task automatic test_illegal(input logic [31:0] enc);
    send(enc);
    checks++; if (fu_ivalid !== 7'd0 || cpu_rsp_valid !== 1'b0) begin failures++; $display("FAIL illegal_decode got=ivalid %b valid %b exp=0 0", fu_ivalid, cpu_rsp_valid); end
    nclk();
    checks++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_status !== 2'd1) begin failures++; $display("FAIL illegal_rsp enc=%h got=valid %b status %0d exp=1 1", enc, cpu_rsp_valid, cpu_rsp_status); end
    checks++; if (fu_ivalid !== 7'd0) begin failures++; $display("FAIL illegal_ivalid got=%b exp=0", fu_ivalid); end
    nclk();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL illegal_idle got=%b exp=0", busy); end
  endtask

  task automatic test_disabled();
    send(32'h0000_00A2);
    checks++; if (fu_ivalid !== 7'd0) begin failures++; $display("FAIL disabled_decode_ivalid got=%b exp=0", fu_ivalid); end
    nclk();
    checks++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_status !== 2'd2) begin failures++; $display("FAIL disabled_rsp got=valid %b status %0d exp=1 2", cpu_rsp_valid, cpu_rsp_status); end
    checks++; if (fu_ivalid !== 7'd0) begin failures++; $display("FAIL disabled_ivalid got=%b exp=0", fu_ivalid); end
    nclk();
  endtask

  // done_last=1 pulses fu_idone[5] in the last allowed EXEC cycle.
  task automatic test_timeout(input logic done_last);
    send(32'h1234_5675);
    for (int i = 0; i < 4; i++) begin
      nclk();
      checks++; if (fu_ivalid !== 7'b0100000 || cpu_rsp_valid !== 1'b0) begin failures++; $display("FAIL timeout_exec%0d got=ivalid %b valid %b exp=0100000 0", i, fu_ivalid, cpu_rsp_valid); end
      if (i == 3 && done_last) fu_idone = 7'b0100000;
    end
    nclk();
    fu_idone = 7'd0;
    checks++; if (fu_ivalid !== 7'd0) begin failures++; $display("FAIL timeout_ivalid_drop got=%b exp=0", fu_ivalid); end
    checks++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_status !== (done_last ? 2'd0 : 2'd3)) begin failures++; $display("FAIL timeout_rsp done=%b got=valid %b status %0d exp=1 %0d", done_last, cpu_rsp_valid, cpu_rsp_status, done_last ? 0 : 3); end
    nclk();
  endtask

  task automatic test_ignore_and_stall();
    cpu_rsp_ready = 1'b0;
    send(32'h0000_0C04);
    nclk();
    checks++; if (fu_ivalid !== 7'b0010000) begin failures++; $display("FAIL stall_ivalid got=%b exp=0010000", fu_ivalid); end
    fu_idone = 7'b0000010;
    nclk();
    checks++; if (fu_ivalid !== 7'b0010000 || cpu_rsp_valid !== 1'b0) begin failures++; $display("FAIL stall_foreign_done got=ivalid %b valid %b exp=0010000 0", fu_ivalid, cpu_rsp_valid); end
    fu_idone = 7'b0010000;
    nclk();
    fu_idone = 7'd0;
    cpu_insn_req = 1'b1;
    cpu_insn_enc = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      checks++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_status !== 2'd0 || cpu_insn_ack !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL stall_hold%0d got=valid %b status %0d ack %b busy %b exp=1 0 0 1", i, cpu_rsp_valid, cpu_rsp_status, cpu_insn_ack, busy); end
      nclk();
    end
    checks++; if (dec_encoded !== 32'h0000_0C04) begin failures++; $display("FAIL stall_no_accept got=%h exp=00000c04", dec_encoded); end
    cpu_insn_req = 1'b0;
    cpu_rsp_ready = 1'b1;
    nclk();
    checks++; if (busy !== 1'b0 || cpu_insn_ack !== 1'b1 || cpu_rsp_valid !== 1'b0) begin failures++; $display("FAIL stall_release got=busy %b ack %b valid %b exp=0 1 0", busy, cpu_insn_ack, cpu_rsp_valid); end
  endtask

  task automatic test_reset_mid_exec();
`ifdef SCARV_COP_DISPATCH_PERF_EN
    checks++; if (perf_retired !== 32'd3 || perf_faults !== 16'd4) begin failures++; $display("FAIL perf_counts got=%0d/%0d exp=3/4", perf_retired, perf_faults); end
`endif
    send(32'h5555_5556);
    nclk();
    checks++; if (fu_ivalid !== 7'b1000000) begin failures++; $display("FAIL rst_exec_ivalid got=%b exp=1000000", fu_ivalid); end
    #2 g_reset = 1'b1;
    #1;
    checks++; if (fu_ivalid !== 7'd0 || busy !== 1'b0 || cpu_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_async got=ivalid %b busy %b valid %b exp=0 0 0", fu_ivalid, busy, cpu_rsp_valid); end
    checks++; if (dec_encoded !== 32'd0) begin failures++; $display("FAIL rst_dec_clear got=%h exp=0", dec_encoded); end
`ifdef SCARV_COP_DISPATCH_PERF_EN
    checks++; if (perf_retired !== 32'd0 || perf_faults !== 16'd0) begin failures++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", perf_retired, perf_faults); end
`endif
    nclk();
    nclk();
    g_reset = 1'b0;
    nclk();
    checks++; if (cpu_rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_no_rsp got=valid %b busy %b exp=0 0", cpu_rsp_valid, busy); end
    send(32'h0000_0013);
    nclk();
    checks++; if (fu_ivalid !== 7'b0001000) begin failures++; $display("FAIL rst_after_ivalid got=%b exp=0001000", fu_ivalid); end
    fu_idone = 7'b0001000;
    nclk();
    fu_idone = 7'd0;
    checks++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_status !== 2'd0) begin failures++; $display("FAIL rst_after_rsp got=valid %b status %0d exp=1 0", cpu_rsp_valid, cpu_rsp_status); end
    nclk();
`ifdef SCARV_COP_DISPATCH_PERF_EN
    checks++; if (perf_retired !== 32'd1 || perf_faults !== 16'd0) begin failures++; $display("FAIL rst_after_perf got=%0d/%0d exp=1/0", perf_retired, perf_faults); end
`endif
  endtask

  initial begin
    nclk();
    nclk();
    g_reset = 1'b0;
    test_reset();
    test_legal();
    test_illegal(32'hF000_0001);
    test_illegal(32'h0000_0017);
    test_disabled();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_ignore_and_stall();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scarv_cop_dispatch.md
Name: scarv_cop_dispatch

Overview:
- Issue/sequencing controller for the crypto coprocessor.
- Accepts one 32-bit encoded instruction at a time from the host CPU and drives the registered encoding into the combinational instruction decoder.
- Checks the decoder's exception and class outputs, then hands the instruction to exactly one per-class functional unit (FU) and waits for completion or watchdog timeout.
- Returns a status response to the CPU. Single-issue, in-order, no pipelining across instructions.

Parameters:
- FEATURE_MASK, 7'h7F, bit n=1 enables the FU for class code n; a disabled class is rejected.
- MAX_CYCLES, 64, watchdog limit in EXEC cycles; legal range 2..65535.

Ports:
- g_clk  in  1  clock, rising edge.
- g_reset  in  1  asynchronous, active-high reset.
- cpu_insn_req  in  1  CPU offers an instruction.
- cpu_insn_ack  out  1  block accepts the instruction; transfer happens when req&ack.
- cpu_insn_enc  in  32  encoded instruction.
- cpu_rsp_valid  out  1  response available.
- cpu_rsp_ready  in  1  CPU consumes the response.
- cpu_rsp_status  out  2  0=OK, 1=ILLEGAL, 2=DISABLED, 3=TIMEOUT.
- dec_encoded  out  32  registered instruction, fed to the decoder's id_encoded.
- id_exception  in  1  decoder illegal-instruction flag.
- id_class  in  3  decoder class code.
- fu_ivalid  out  7  one-hot issue strobe; bit n = class n.
- fu_idone  in  7  FU completion pulses.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, DECODE, EXEC, RESP. Encoded 2 bits; unreachable codes go to IDLE.
- Reset (asynchronous, active-high) drives all of the following immediately, including mid-operation:
  - state=IDLE, dec_encoded=0, fu_ivalid=0, cpu_rsp_valid=0, cpu_rsp_status=0, watchdog=0.
  - Any in-flight instruction is discarded; no response is produced for it.
- cpu_insn_ack = (state==IDLE), combinational.
- IDLE, when req&ack at edge T:
  - dec_encoded <= cpu_insn_enc.
  - Go to DECODE at T+1.
  - cpu_insn_enc is ignored when no transfer occurs.
- DECODE (one cycle). Decoder outputs are sampled, and the checks apply in priority order:
  - id_exception=1 or id_class=7 -> status ILLEGAL, go to RESP.
  - else FEATURE_MASK[id_class]=0 -> status DISABLED, go to RESP.
  - else latch the class into cls_q, clear the watchdog, go to EXEC.
- EXEC:
  - fu_ivalid = one-hot(cls_q), held high every EXEC cycle.
  - fu_idone[cls_q]=1 -> status OK, go to RESP next edge. Completion may arrive in the first EXEC cycle.
  - fu_idone bits other than cls_q are ignored.
  - The watchdog increments each EXEC cycle without completion. When it equals MAX_CYCLES-1 with no done -> status TIMEOUT, go to RESP; fu_ivalid drops.
  - If done and timeout coincide, done wins (status OK).
- RESP:
  - cpu_rsp_valid=1 with status stable.
  - On rsp_ready -> IDLE.
  - A new instruction can be accepted no earlier than the cycle after the response handshake.
- Minimum latency: accept at T, DECODE at T+1, EXEC at T+2 (done same cycle), cpu_rsp_valid at T+3. Best-case throughput is one instruction per 4 cycles.
- dec_encoded holds its value until the next accepted instruction. It is not cleared on return to IDLE.
- Watchdog is a 16-bit counter; it never wraps because it is limited by MAX_CYCLES.

Optional Feature:
- SCARV_COP_DISPATCH_PERF_EN defined:
  - Adds output perf_retired (32 bits), which increments on each response handshake with status OK.
  - Adds output perf_faults (16 bits), which increments on each handshake with a non-OK status.
  - Both counters reset to 0, wrap modulo 2^width, and saturate never.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Legal instruction, decoder class=3, fu_idone[3] pulsed the first EXEC cycle, rsp_ready tied 1:
  - ack at T; fu_ivalid=7'b0001000 at T+2 only.
  - rsp_valid at T+3, status=0; busy falls at T+4.
- id_exception=1 in DECODE -> no fu_ivalid bit ever rises; status=1, one cycle after DECODE.
- FEATURE_MASK=7'h7B, class=2 -> status=2, fu_ivalid stays 0.
- MAX_CYCLES=4, class=5, fu_idone never asserted:
  - fu_ivalid[5] high for exactly 4 cycles; then status=3.
  - Repeat with fu_idone[5] on the 4th cycle -> status=0.
- fu_idone[1] asserted while cls_q=4 -> ignored, still in EXEC. Then hold rsp_ready=0 for 5 cycles -> rsp_valid and status stable, ack=0 throughout.
- Assert g_reset mid-EXEC (asynchronous, between edges) -> fu_ivalid, busy and rsp_valid are 0 immediately. After release, a new instruction is accepted and completes normally. With PERF_EN, counters read 0 after reset.
